// File: rtl/rmii_mac_tx_if.sv
// Byte-stream handshake feeding the RMII transmit MAC.
interface rmii_mac_tx_if;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tlast;
  logic       s_tready;

  modport master (output s_tdata, s_tvalid, s_tlast, input s_tready);
  modport slave  (input s_tdata, s_tvalid, s_tlast, output s_tready);
endinterface

// File: rtl/rmii_mac_tx.sv
// RMII Ethernet MAC transmit path: preamble/SFD, payload, zero pad, CRC-32 FCS, IFG.
// One dibit per 50 MHz cycle, LSB dibit first; every output is registered.
module rmii_mac_tx #(
  parameter int unsigned PREAMBLE_BYTES  = 7,
  parameter int unsigned MIN_FRAME_BYTES = 60,
  parameter int unsigned IFG_BYTES       = 12
) (
  input  logic         CLK,
  input  logic         RST_N,
  rmii_mac_tx_if.slave s_axis,
  output logic         ETH_TXEN,
  output logic [1:0]   ETH_TXD,
  output logic         busy,
  output logic         frame_done,
  output logic         underrun
);
  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IFG} state_t;

  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_BYTES - 1);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);
  localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME_BYTES);

  state_t      state, state_n;
  logic [1:0]  cnt, cnt_n;
  logic [7:0]  bcnt, bcnt_n;
  logic [10:0] byte_cnt, byte_cnt_n, byte_inc;
  logic [7:0]  tx_byte, tx_byte_n;
  logic        cur_last, last_n;
  logic [31:0] crc, crc_n, crc_upd;
  logic        txen_n, tready_n, busy_n, done_n, und_n;
  logic [1:0]  txd_n;
  logic        fetch, to_fcs, go_gap;

  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 2; i++)
      r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  always_comb begin
    state_n    = state;
    cnt_n      = cnt + 2'd1;
    bcnt_n     = bcnt;
    byte_cnt_n = byte_cnt;
    tx_byte_n  = tx_byte;
    last_n     = cur_last;
    crc_n      = crc;
    txen_n     = 1'b0;
    txd_n      = 2'b00;
    tready_n   = 1'b0;
    busy_n     = 1'b1;
    done_n     = 1'b0;
    und_n      = 1'b0;
    fetch      = 1'b0;
    to_fcs     = 1'b0;
    go_gap     = 1'b0;
    // CRC absorbs the dibit currently on the wire, so it is current at each edge
    crc_upd    = crc_dibit(crc, ETH_TXD);
    byte_inc   = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;

    unique case (state)
      IDLE: begin
        busy_n     = s_axis.s_tvalid;
        cnt_n      = '0;
        bcnt_n     = '0;
        byte_cnt_n = '0;
        crc_n      = '1;
        if (s_axis.s_tvalid) begin
          state_n = (PREAMBLE_BYTES == 0) ? SFD : PRE;
          txen_n  = 1'b1;
          txd_n   = 2'b01;
        end
      end
      PRE: begin
        txen_n = 1'b1;
        txd_n  = 2'b01;
        if (cnt == 2'd3) begin
          bcnt_n = bcnt + 8'd1;
          if (bcnt == PRE_LAST) begin
            state_n = SFD;
            bcnt_n  = '0;
          end
        end
      end
      SFD: begin
        txen_n   = 1'b1;
        txd_n    = (cnt_n == 2'd3) ? 2'b11 : 2'b01;
        tready_n = (cnt_n == 2'd3);
        fetch    = (cnt == 2'd3);
      end
      DATA: begin
        txen_n   = 1'b1;
        crc_n    = crc_upd;
        txd_n    = tx_byte[{cnt_n, 1'b0} +: 2];
        tready_n = (cnt_n == 2'd3) && !cur_last;
        if (cnt == 2'd3) begin
          byte_cnt_n = byte_inc;
          if (!cur_last) fetch = 1'b1;
          else if (byte_inc < MIN_LEN) begin
            state_n   = PAD;
            tx_byte_n = '0;
            txd_n     = 2'b00;
          end else to_fcs = 1'b1;
        end
      end
      PAD: begin
        txen_n = 1'b1;
        crc_n  = crc_upd;
        if (cnt == 2'd3) begin
          byte_cnt_n = byte_inc;
          to_fcs     = (byte_inc >= MIN_LEN);
        end
      end
      FCS: begin
        txen_n = 1'b1;
        txd_n  = ~crc[1:0];
        crc_n  = crc >> 2;
        done_n = (bcnt == 8'd3) && (cnt_n == 2'd3);
        if (cnt == 2'd3) begin
          bcnt_n = bcnt + 8'd1;
          go_gap = (bcnt == 8'd3);
        end
      end
      IFG: begin
        if (cnt == 2'd3) begin
          bcnt_n = bcnt + 8'd1;
          if (bcnt == IFG_LAST) begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase

    if (fetch) begin
      if (s_axis.s_tvalid) begin
        state_n   = DATA;
        tx_byte_n = s_axis.s_tdata;
        last_n    = s_axis.s_tlast;
        txen_n    = 1'b1;
        txd_n     = s_axis.s_tdata[1:0];
        tready_n  = 1'b0;
      end else begin
        und_n  = 1'b1;
        go_gap = 1'b1;
      end
    end

    // FCS is shifted out of the CRC register; the first dibit comes from the final update
    if (to_fcs) begin
      state_n = FCS;
      txen_n  = 1'b1;
      txd_n   = ~crc_upd[1:0];
      crc_n   = crc_upd >> 2;
      bcnt_n  = '0;
    end

    if (go_gap) begin
      state_n  = (IFG_BYTES == 0) ? IDLE : IFG;
      busy_n   = (IFG_BYTES != 0);
      txen_n   = 1'b0;
      txd_n    = 2'b00;
      tready_n = 1'b0;
      bcnt_n   = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state           <= IDLE;
      cnt             <= '0;
      bcnt            <= '0;
      byte_cnt        <= '0;
      tx_byte         <= '0;
      cur_last        <= 1'b0;
      crc             <= '1;
      ETH_TXEN        <= 1'b0;
      ETH_TXD         <= 2'b00;
      s_axis.s_tready <= 1'b0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      underrun        <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      bcnt            <= bcnt_n;
      byte_cnt        <= byte_cnt_n;
      tx_byte         <= tx_byte_n;
      cur_last        <= last_n;
      crc             <= crc_n;
      ETH_TXEN        <= txen_n;
      ETH_TXD         <= txd_n;
      s_axis.s_tready <= tready_n;
      busy            <= busy_n;
      frame_done      <= done_n;
      underrun        <= und_n;
    end
  end
endmodule

// File: tb/tb_rmii_mac_tx.sv
// Self-checking bench for rmii_mac_tx: expected wire dibits are queued per frame and popped against the PHY side.
module tb_rmii_mac_tx;
  localparam int PRE = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  logic [7:0] tdata = '0;
  logic       tvalid = 1'b0;
  logic       tlast = 1'b0;
  logic       sel = 1'b1;

  rmii_mac_tx_if if0 ();
  rmii_mac_tx_if if1 ();
  assign if0.s_tdata  = tdata;
  assign if0.s_tvalid = tvalid;
  assign if0.s_tlast  = tlast;
  assign if1.s_tdata  = tdata;
  assign if1.s_tvalid = tvalid;
  assign if1.s_tlast  = tlast;

  logic       txen0, txen1, busy0, busy1, done0, done1, und0, und1;
  logic [1:0] txd0, txd1;

  rmii_mac_tx #(.MIN_FRAME_BYTES(0)) dut0 (
    .CLK(clk), .RST_N(rst_n), .s_axis(if0.slave), .ETH_TXEN(txen0), .ETH_TXD(txd0),
    .busy(busy0), .frame_done(done0), .underrun(und0));

  rmii_mac_tx dut1 (
    .CLK(clk), .RST_N(rst_n), .s_axis(if1.slave), .ETH_TXEN(txen1), .ETH_TXD(txd1),
    .busy(busy1), .frame_done(done1), .underrun(und1));

  logic       txen, busy, done, und, tready;
  logic [1:0] txd;
  always_comb begin
    if (sel) begin
      txen = txen1; txd = txd1; busy = busy1; done = done1; und = und1; tready = if1.s_tready;
    end else begin
      txen = txen0; txd = txd0; busy = busy0; done = done0; und = und0; tready = if0.s_tready;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  frm[$];
  logic [7:0]  pay_q[$];
  logic        last_q[$];
  logic [1:0]  exp_q[$];
  logic [1:0]  obs_q[$];
  logic [31:0] exp_fcs;
  int txen_cyc, done_cnt, done_pos, und_cnt, busy_after_und, tready_cnt, gap_len;
  bit timeout;

  task automatic apply_reset(input logic s);
    sel = s;
    pay_q.delete(); last_q.delete(); exp_q.delete(); obs_q.delete();
    tvalid = 1'b0; tlast = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic load_frame();
    foreach (frm[i]) begin
      pay_q.push_back(frm[i]);
      last_q.push_back(i == frm.size() - 1);
    end
  endtask

  // Builds the expected wire image; cut >= 0 keeps only that many payload bytes and no FCS.
  task automatic expect_frame(input int min_len, input int cut);
    logic [7:0]  f[$];
    logic [31:0] c;
    f = frm;
    for (int i = 0; i < PRE * 4 + 3; i++) exp_q.push_back(2'b01);
    exp_q.push_back(2'b11);
    if (cut >= 0) while (f.size() > cut) void'(f.pop_back());
    else while (f.size() < min_len) f.push_back(8'h00);
    foreach (f[i]) for (int d = 0; d < 4; d++) exp_q.push_back(f[i][2*d +: 2]);
    if (cut < 0) begin
      c = '1;
      foreach (f[i]) begin
        c ^= {24'h0, f[i]};
        for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      exp_fcs = ~c;
      for (int d = 0; d < 16; d++) exp_q.push_back(exp_fcs[2*d +: 2]);
    end
  endtask

  task automatic run_stream(input int max_cycles, input int drop_at);
    int  idx = 0;
    int  zeros = 0;
    bit  seen = 0, fell = 0, und_seen = 0, take;
    obs_q.delete();
    txen_cyc = 0; done_cnt = 0; done_pos = -1; und_cnt = 0; busy_after_und = 0;
    tready_cnt = 0; gap_len = -1; timeout = 1'b1;
    tvalid = (pay_q.size() > 0);
    if (tvalid) begin tdata = pay_q[0]; tlast = last_q[0]; end
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      if (txen) begin
        if (fell && gap_len < 0) gap_len = zeros;
        obs_q.push_back(txd);
        txen_cyc++;
        seen = 1;
      end else if (seen) begin
        fell = 1;
        zeros++;
      end
      if (done) begin done_cnt++; done_pos = txen_cyc; end
      if (und) begin und_cnt++; und_seen = 1; end
      if (und_seen && busy) busy_after_und++;
      if (tready) tready_cnt++;
      if (seen && !busy && !tvalid) begin timeout = 1'b0; break; end
      take = tready && tvalid;
      @(posedge clk);
      #1;
      if (take) idx++;
      if (drop_at >= 0 && idx >= drop_at) idx = pay_q.size();
      tvalid = (idx < pay_q.size());
      if (tvalid) begin tdata = pay_q[idx]; tlast = last_q[idx]; end
      else tlast = 1'b0;
    end
    tvalid = 1'b0;
  endtask

  function automatic logic [7:0] obs_byte(input int k);
    int b = PRE * 4 + 4 + 4 * k;
    if (b + 3 >= obs_q.size()) return 'x;
    return {obs_q[b+3], obs_q[b+2], obs_q[b+1], obs_q[b]};
  endfunction

  function automatic int wire_diffs();
    int d = 0;
    if (obs_q.size() != exp_q.size()) d++;
    while (exp_q.size() > 0 && obs_q.size() > 0)
      if (exp_q.pop_front() !== obs_q.pop_front()) d++;
    exp_q.delete(); obs_q.delete();
    return d;
  endfunction

  task automatic test_reset();
    sel = 1'b1; rst_n = 1'b0; tvalid = 1'b1; tdata = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({txen, txd, tready, busy, done, und} !== 7'b0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got txen=%b txd=%b tready=%b busy=%b done=%b und=%b, all 0 required",
                 i, txen, txd, tready, busy, done, und);
      end
    end
    tvalid = 1'b0;
  endtask

  task automatic test_check_value();
    string s = "123456789";
    logic [31:0] fcs;
    int d;
    apply_reset(1'b0);
    frm.delete();
    for (int i = 0; i < s.len(); i++) frm.push_back(s[i]);
    load_frame();
    expect_frame(0, -1);
    run_stream(2000, -1);
    n_tests++; if (timeout) begin n_fail++; $display("FAIL nopad_timeout: frame did not end within budget"); end
    n_tests++; if (txen_cyc !== 84) begin n_fail++; $display("FAIL nopad_txen_cycles: got %0d, want 84", txen_cyc); end
    n_tests++; if (done_cnt !== 1 || done_pos !== 84) begin
      n_fail++; $display("FAIL nopad_frame_done: got %0d pulses at cycle %0d, want 1 at 84", done_cnt, done_pos); end
    n_tests++; if (tready_cnt !== 9) begin n_fail++; $display("FAIL nopad_tready_cycles: got %0d, want 9", tready_cnt); end
    fcs = {obs_byte(12), obs_byte(11), obs_byte(10), obs_byte(9)};
    n_tests++; if (fcs !== 32'hCBF43926) begin n_fail++; $display("FAIL nopad_fcs: got %h, want cbf43926", fcs); end
    d = wire_diffs();
    n_tests++; if (d !== 0) begin n_fail++; $display("FAIL nopad_wire: %0d dibit differences, want 0", d); end
  endtask

  task automatic test_padding();
    int zeros = 0;
    int d;
    logic [31:0] fcs;
    apply_reset(1'b1);
    frm.delete();
    for (int i = 0; i < 14; i++) frm.push_back(8'($urandom_range(1, 255)));
    load_frame();
    expect_frame(60, -1);
    run_stream(2000, -1);
    n_tests++; if (timeout) begin n_fail++; $display("FAIL pad_timeout: frame did not end within budget"); end
    n_tests++; if (txen_cyc !== 288) begin n_fail++; $display("FAIL pad_txen_cycles: got %0d, want 288", txen_cyc); end
    for (int k = 14; k < 60; k++) if (obs_byte(k) === 8'h00) zeros++;
    n_tests++; if (zeros !== 46) begin n_fail++; $display("FAIL pad_zero_bytes: got %0d, want 46", zeros); end
    fcs = {obs_byte(63), obs_byte(62), obs_byte(61), obs_byte(60)};
    n_tests++; if (fcs !== exp_fcs) begin n_fail++; $display("FAIL pad_fcs: got %h, want %h", fcs, exp_fcs); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL pad_frame_done: got %0d pulses, want 1", done_cnt); end
    d = wire_diffs();
    n_tests++; if (d !== 0) begin n_fail++; $display("FAIL pad_wire: %0d dibit differences, want 0", d); end
  endtask

  task automatic test_underrun();
    int d;
    apply_reset(1'b1);
    frm.delete();
    for (int i = 0; i < 10; i++) frm.push_back(8'($urandom));
    load_frame();
    expect_frame(60, 5);
    run_stream(2000, 5);
    n_tests++; if (timeout) begin n_fail++; $display("FAIL und_timeout: frame did not end within budget"); end
    n_tests++; if (und_cnt !== 1) begin n_fail++; $display("FAIL und_pulses: got %0d, want 1", und_cnt); end
    n_tests++; if (txen_cyc !== 52) begin n_fail++; $display("FAIL und_txen_cycles: got %0d, want 52", txen_cyc); end
    n_tests++; if (busy_after_und !== 48) begin n_fail++; $display("FAIL und_busy_tail: got %0d, want 48", busy_after_und); end
    n_tests++; if (done_cnt !== 0) begin n_fail++; $display("FAIL und_frame_done: got %0d pulses, want 0", done_cnt); end
    d = wire_diffs();
    n_tests++; if (d !== 0) begin n_fail++; $display("FAIL und_wire: %0d dibit differences, want 0", d); end
  endtask

  task automatic test_back_to_back();
    int d;
    apply_reset(1'b1);
    frm.delete();
    for (int i = 0; i < 20; i++) frm.push_back(8'($urandom));
    load_frame();
    expect_frame(60, -1);
    frm.delete();
    for (int i = 0; i < 64; i++) frm.push_back(8'($urandom));
    load_frame();
    expect_frame(60, -1);
    run_stream(3000, -1);
    n_tests++; if (timeout) begin n_fail++; $display("FAIL b2b_timeout: frames did not end within budget"); end
    n_tests++; if (gap_len !== 49) begin n_fail++; $display("FAIL b2b_gap: got %0d idle cycles, want 49", gap_len); end
    n_tests++; if (done_cnt !== 2) begin n_fail++; $display("FAIL b2b_frame_done: got %0d pulses, want 2", done_cnt); end
    n_tests++; if (txen_cyc !== 592) begin n_fail++; $display("FAIL b2b_txen_cycles: got %0d, want 592", txen_cyc); end
    d = wire_diffs();
    n_tests++; if (d !== 0) begin n_fail++; $display("FAIL b2b_wire: %0d dibit differences, want 0", d); end
  endtask

  task automatic test_reset_mid_frame();
    int  on = 0;
    bit  hit = 0;
    int  d;
    apply_reset(1'b1);
    tdata = 8'hA5; tlast = 1'b0; tvalid = 1'b1;
    for (int c = 0; c < 400 && !hit; c++) begin
      @(negedge clk);
      if (txen) on++;
      if (on == 40) hit = 1;
    end
    n_tests++; if (!hit) begin n_fail++; $display("FAIL midrst_reach_data: got %0d txen cycles, want 40", on); end
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++; if ({txen, busy, tready} !== 3'b000) begin
      n_fail++; $display("FAIL midrst_drop: got txen=%b busy=%b tready=%b, want 000", txen, busy, tready); end
    @(posedge clk);
    #1 rst_n = 1'b1; tvalid = 1'b0;
    frm.delete();
    for (int i = 0; i < 12; i++) frm.push_back(8'($urandom));
    load_frame();
    expect_frame(60, -1);
    run_stream(2000, -1);
    n_tests++; if (txen_cyc !== 288) begin n_fail++; $display("FAIL midrst_txen_cycles: got %0d, want 288", txen_cyc); end
    d = wire_diffs();
    n_tests++; if (d !== 0) begin n_fail++; $display("FAIL midrst_wire: %0d dibit differences, want 0", d); end
  endtask

  initial begin
    test_reset();
    test_check_value();
    test_padding();
    test_underrun();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rmii_mac_tx.md
Name: rmii_mac_tx

Overview:
- Ethernet MAC transmit path for the RMII PHY interface. Drives ETH_TXEN/ETH_TXD toward the PHY. It is the transmit counterpart of the receive path that consumes ETH_CRSDV/ETH_RXD in eth_top.
- Accepts a byte stream with a valid/ready/last handshake. Emits the preamble, SFD, payload, zero padding up to the minimum frame length, the CRC-32 FCS, and the inter-frame gap.
- Runs entirely on the 50 MHz RMII reference clock and sends one dibit per cycle.

Parameters:
- PREAMBLE_BYTES, 7, number of 0x55 bytes sent before the SFD.
- MIN_FRAME_BYTES, 60, minimum payload bytes before the FCS. Shorter payloads are zero-padded to this length. A value of 0 disables padding.
- IFG_BYTES, 12, inter-frame gap in byte times. Each byte time is 4 cycles.

Ports:
- CLK  input  1  50 MHz RMII reference clock; the only clock.
- RST_N  input  1  synchronous, active-low reset.
- s_tdata  input  8  payload byte (destination MAC first).
- s_tvalid  input  1  s_tdata is valid.
- s_tlast  input  1  current byte is the last payload byte.
- s_tready  output  1  block consumes s_tdata this cycle.
- ETH_TXEN  output  1  RMII transmit enable.
- ETH_TXD  output  2  RMII transmit dibit.
- busy  output  1  high from frame start through the end of the IFG.
- frame_done  output  1  one-cycle pulse on the last FCS dibit.
- underrun  output  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset: while RST_N=0 at a CLK edge, all outputs are 0 and the state is IDLE. Reset mid-frame drops ETH_TXEN on the next edge and sends no FCS.
- All outputs are registered.
- Dibit order: LSB dibit first, so byte bits [1:0], then [3:2], [5:4], [7:6]. A 2-bit counter selects the dibit and wraps every 4 cycles. One byte time is 4 cycles.
- State machine:
  - IDLE: on s_tvalid=1, the next cycle enters PRE with ETH_TXEN=1, ETH_TXD=01. No byte is consumed in IDLE.
  - PRE: sends PREAMBLE_BYTES x 0x55 (dibit 01 every cycle), then goes to SFD.
  - SFD: sends 0xD5 as dibits 01,01,01,11. s_tready=1 on the last SFD dibit cycle, loading the first payload byte.
  - DATA: sends the loaded byte. s_tready=1 on dibit 3 of each byte unless the current byte carried s_tlast.
    - If s_tready=1 and s_tvalid=0, the block pulses underrun, drops ETH_TXEN the next cycle, and goes to IFG.
    - After the tlast byte: go to PAD if the byte count is below MIN_FRAME_BYTES, else go to FCS.
  - PAD: sends 0x00 bytes until the byte count equals MIN_FRAME_BYTES, then goes to FCS.
  - FCS: sends 4 bytes, 16 cycles. frame_done pulses on the final dibit, then the block goes to IFG.
  - IFG: ETH_TXEN=0 and ETH_TXD=00 for IFG_BYTES*4 cycles, then the block goes to IDLE.
- busy is 1 in every state except IDLE.
- s_tready is 0 outside SFD and DATA.
- Byte counter: 11 bits. It counts payload and pad bytes and saturates at 2047. Frames of any length are sent.
- CRC-32:
  - Reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF.
  - Updated over payload and pad bytes only, not preamble or SFD.
  - FCS = ~crc. It is sent least-significant byte first, each byte LSB dibit first.
  - The CRC is updated 2 bits per cycle, and the register is re-initialised in IDLE.
- Simultaneous events: s_tvalid held high during IFG is ignored until IDLE. Back-to-back frames therefore have exactly IFG_BYTES*4 idle cycles plus 1 IDLE cycle between them.
- Latency: from an IDLE cycle with s_tvalid=1, ETH_TXEN rises 1 cycle later. The first payload dibit appears (PREAMBLE_BYTES+1)*4 cycles after ETH_TXEN rises.

Test Plan:
- Reset: hold RST_N=0 for 3 cycles with s_tvalid=1 -> ETH_TXEN=0, ETH_TXD=00, s_tready=0, busy=0 throughout.
- MIN_FRAME_BYTES=0, payload ASCII "123456789" with tlast on '9':
  - ETH_TXEN high for exactly 84 cycles: 32 preamble/SFD, 36 data, 16 FCS.
  - FCS bytes on the wire are 26 39 F4 CB.
  - frame_done pulses once, on the 84th cycle.
- Default params, 14-byte payload:
  - 46 zero pad bytes are sent.
  - ETH_TXEN high for 32+240+16 = 288 cycles.
  - FCS matches a software CRC-32 over 60 bytes.
- Underrun: drop s_tvalid at payload byte 5 -> underrun pulses once, ETH_TXEN falls the next cycle, and no FCS is sent. busy stays high for 48 more cycles.
- Back-to-back frames with s_tvalid held high:
  - Exactly 49 cycles of ETH_TXEN=0 between the two frames.
  - Second frame has a correct preamble and FCS.
- Reset asserted mid-DATA -> ETH_TXEN=0 on the next edge. After release, the next frame starts cleanly with initial CRC 0xFFFFFFFF.
